channel_drain_arbiter: RTL

- Round-robin scheduler that drains complete packets from NUM_CHAN per-channel packet buffers into one shared TX consumer.
- Each buffer exposes:
  - a show-ahead 32-bit read word;
  - a packet_waiting flag;
  - RD (advance one word) and RD_done (release the packet) strobes.
- The block owns exactly one buffer at a time. It forwards that buffer's whole packet over a valid/ready stream, then releases the buffer with a single RD_done pulse.
- Sits between the channel buffers and the TX packet disassembler.

---
 rtl/channel_drain_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/channel_drain_arbiter.sv
// Round-robin drain of complete packets from NUM_CHAN show-ahead channel buffers into one TX stream.
// Optional macro CHAN0_PRIORITY_EN: channel 0 gets strict priority and does not advance rr_ptr.
module channel_drain_arbiter #(
   parameter int NUM_CHAN  = 4,
   parameter int MAX_WORDS = 128,
   parameter int CHW       = 3
) (
   input  logic                    txclk,
   input  logic                    reset,
   input  logic [NUM_CHAN-1:0]     chan_enable,
   input  logic [NUM_CHAN-1:0]     packet_waiting,
   input  logic [32*NUM_CHAN-1:0]  chan_data,
   output logic [NUM_CHAN-1:0]     RD,
   output logic [NUM_CHAN-1:0]     RD_done,
   output logic [31:0]             out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_sop,
   output logic                    out_eop,
   output logic [CHW-1:0]          out_chan,
   output logic                    busy
);

   typedef enum logic [2:0] {S_IDLE, S_GRANT, S_HDR, S_PAYLOAD, S_DONE} state_t;

   localparam int unsigned NC   = NUM_CHAN;
   localparam logic [8:0]  MAXW = 9'(MAX_WORDS);

   state_t               state, state_nxt;
   logic [NUM_CHAN-1:0]  req;
   logic [NUM_CHAN-1:0]  chan_onehot;
   logic [CHW-1:0]       rr_ptr;
   logic [CHW-1:0]       rr_next;
   logic [CHW-1:0]       grant_idx;
   logic                 grant_found;
   int unsigned          cand;
   logic                 gap;
   logic [8:0]           wcnt;
   logic [8:0]           total;
   logic [9:0]           hdr_words;
   logic [8:0]           hdr_total;
   logic                 accept;
   logic                 last_word;
   logic                 adv_rd;

   assign req       = packet_waiting & chan_enable;
   assign accept    = out_valid & out_ready;
   assign last_word = (wcnt == total - 9'd1);
   assign adv_rd    = accept && !(state == S_PAYLOAD && last_word);
   assign rr_next   = (out_chan == CHW'(NC - 1)) ? '0 : out_chan + 1'b1;

   // header word: 2 + ceil(bytes/4) words, clamped to buffer capacity
   assign hdr_words = 10'd2 + ((10'(out_data[8:0]) + 10'd3) >> 2);
   assign hdr_total = (hdr_words > {1'b0, MAXW}) ? MAXW : hdr_words[8:0];

   always_comb begin
      out_data = '0;
      for (int unsigned j = 0; j < NC; j++) begin
         if (out_chan == CHW'(j))
            out_data = chan_data[32*j +: 32];
      end
   end

   always_comb begin
      chan_onehot = '0;
      for (int unsigned j = 0; j < NC; j++)
         chan_onehot[j] = (out_chan == CHW'(j));
   end

   // first requester at or after rr_ptr, modulo NUM_CHAN
   always_comb begin
      grant_idx   = '0;
      grant_found = 1'b0;
      cand        = 0;
`ifdef CHAN0_PRIORITY_EN
      if (req[0])
         grant_found = 1'b1;
`endif
      for (int unsigned k = 0; k < NC; k++) begin
         cand = 32'(rr_ptr) + k;
         if (cand >= NC)
            cand = cand - NC;
         for (int unsigned j = 0; j < NC; j++) begin
            if (!grant_found && cand == j && req[j]) begin
               grant_found = 1'b1;
               grant_idx   = CHW'(j);
            end
         end
      end
   end

   always_ff @(posedge txclk or negedge reset) begin
      if (!reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (|req) state_nxt = S_GRANT;
         S_GRANT:   state_nxt = grant_found ? S_HDR : S_IDLE;
         S_HDR:     if (accept) state_nxt = S_PAYLOAD;
         S_PAYLOAD: if (accept && last_word) state_nxt = S_DONE;
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != S_IDLE);
      out_valid = (state == S_HDR || state == S_PAYLOAD) && !gap;
      out_sop   = (state == S_HDR) && !gap;
      out_eop   = (state == S_PAYLOAD) && !gap && last_word;
   end

   // RD lands in the bubble cycle after an accept so the show-ahead word is fresh on the next valid
   always_ff @(posedge txclk or negedge reset) begin
      if (!reset) begin
         RD       <= '0;
         RD_done  <= '0;
         gap      <= 1'b0;
         wcnt     <= '0;
         total    <= '0;
         out_chan <= '0;
         rr_ptr   <= '0;
      end else begin
         gap     <= adv_rd;
         RD      <= adv_rd ? chan_onehot : '0;
         RD_done <= (accept && state == S_PAYLOAD && last_word) ? chan_onehot : '0;
         case (state)
            S_GRANT: begin
               wcnt <= '0;
               if (grant_found)
                  out_chan <= grant_idx;
            end
            S_HDR: begin
               if (accept) begin
                  total <= hdr_total;
                  wcnt  <= 9'd1;
               end
            end
            S_PAYLOAD: begin
               if (accept)
                  wcnt <= wcnt + 9'd1;
            end
            S_DONE: begin
`ifdef CHAN0_PRIORITY_EN
               if (out_chan != '0)
                  rr_ptr <= rr_next;
`else
               rr_ptr <= rr_next;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
